// File: rtl/mem_stage.sv
// mem_stage: memory-access stage driving the SRAM-like data bus, with load alignment,
// address-error detection and the MEM/WB pipeline register.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        MemReadType_i,
  input  logic [ADDR_W-1:0] ALUResult_i,
  input  logic [ADDR_W-1:0] MemData_i,
  input  logic [REG_W-1:0]  WriteRegister_i,
  input  logic [ADDR_W-1:0] PCin,
  input  logic              exception_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [ADDR_W-1:0] data_rdata,
  output logic              stall,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_W-1:0]  WriteRegister_o,
  output logic [ADDR_W-1:0] ALUResult_o,
  output logic [ADDR_W-1:0] ReadData_o,
  output logic [ADDR_W-1:0] PCout,
  output logic              AdEL,
  output logic              AdES,
  output logic [ADDR_W-1:0] BadVAddr
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  function automatic logic [ADDR_W-1:0] lanes(input logic [ADDR_W-1:0] d, input logic [1:0] sz);
    return sz == 2'b00 ? {(ADDR_W/8){d[7:0]}} : sz == 2'b01 ? {(ADDR_W/16){d[15:0]}} : d;
  endfunction
  function automatic logic [ADDR_W-1:0] extract(input logic [ADDR_W-1:0] w, input logic [2:0] t,
                                                input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return t[1:0] == 2'b00 ? {{(ADDR_W-8){~t[2] & b[7]}}, b} :
           t[1:0] == 2'b01 ? {{(ADDR_W-16){~t[2] & h[15]}}, h} : w;
  endfunction
  state_t              state_q, state_d;
  logic                mem_op, mis, idle, idle_go, done_idle, busy, issue;
  logic [ADDR_W-1:0]   addr_q, wdata_q, pc_q;
  logic [2:0]          type_q;
  logic [REG_W-1:0]    wreg_q;
  logic                wr_q, load_q, rw_q, m2r_q, kill_q;
  logic                valid_d, regwrite_d, memtoreg_d, adel_d, ades_d;
  logic [REG_W-1:0]    wreg_d;
  logic [ADDR_W-1:0]   alu_d, rdata_d, pc_d, badv_d;
  assign mem_op    = valid_i & (MemRead_i | MemWrite_i) & ~exception_i & ~flush;
  assign mis       = (MemReadType_i[1:0] == 2'b01 & ALUResult_i[0]) |
                     (MemReadType_i[1:0] == 2'b10 & |ALUResult_i[1:0]);
  assign idle      = state_q == S_IDLE;
  assign idle_go   = idle & mem_op & ~mis;
  assign done_idle = idle_go & data_addr_ok & data_data_ok;
  assign issue     = idle_go & ~done_idle;
  assign busy      = ~idle;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = idle ? (issue ? (data_addr_ok ? S_WAIT : S_REQ) : S_IDLE) :
              state_q == S_REQ ? (data_addr_ok ? S_WAIT : S_REQ) :
              (data_data_ok ? S_IDLE : S_WAIT);
  end
  always_comb begin
    data_req   = idle_go | state_q == S_REQ;
    stall      = (idle_go & ~(data_addr_ok & data_data_ok)) | state_q == S_REQ |
                 (state_q == S_WAIT & ~data_data_ok);
    data_wr    = idle ? MemWrite_i : wr_q;
    data_size  = idle ? MemReadType_i[1:0] : type_q[1:0];
    data_addr  = idle ? ALUResult_i : addr_q;
    data_wdata = idle ? lanes(MemData_i, MemReadType_i[1:0]) : wdata_q;
  end
  // Bus fields and instruction info are frozen at issue so a later flush or upstream change cannot disturb them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      type_q  <= '0;
      wreg_q  <= '0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else if (issue) begin
      addr_q  <= ALUResult_i;
      wdata_q <= lanes(MemData_i, MemReadType_i[1:0]);
      pc_q    <= PCin;
      type_q  <= MemReadType_i;
      wreg_q  <= WriteRegister_i;
      wr_q    <= MemWrite_i;
      load_q  <= MemRead_i;
      rw_q    <= RegWrite_i;
      m2r_q   <= MemtoReg_i;
      kill_q  <= 1'b0;
    end else if (busy & flush) begin
      kill_q  <= 1'b1;
    end
  end
  always_comb begin
    valid_d    = busy ? ~kill_q : valid_i & ~flush;
    regwrite_d = busy ? rw_q & ~kill_q : RegWrite_i & valid_i & ~flush & ~exception_i & ~(mem_op & mis);
    memtoreg_d = busy ? m2r_q : MemtoReg_i;
    wreg_d     = busy ? wreg_q : WriteRegister_i;
    alu_d      = busy ? addr_q : ALUResult_i;
    pc_d       = busy ? pc_q : PCin;
    rdata_d    = busy ? (load_q ? extract(data_rdata, type_q, addr_q[1:0]) : '0) :
                 (done_idle & MemRead_i ? extract(data_rdata, MemReadType_i, ALUResult_i[1:0]) : '0);
    adel_d     = ~busy & mem_op & mis & MemRead_i;
    ades_d     = ~busy & mem_op & mis & MemWrite_i;
    badv_d     = ~busy & mem_op & mis ? ALUResult_i : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o         <= 1'b0;
      RegWrite_o      <= 1'b0;
      MemtoReg_o      <= 1'b0;
      WriteRegister_o <= '0;
      ALUResult_o     <= '0;
      ReadData_o      <= '0;
      PCout           <= '0;
      AdEL            <= 1'b0;
      AdES            <= 1'b0;
      BadVAddr        <= '0;
    end else if (stall) begin
      valid_o         <= 1'b0;
      RegWrite_o      <= 1'b0;
    end else begin
      valid_o         <= valid_d;
      RegWrite_o      <= regwrite_d;
      MemtoReg_o      <= memtoreg_d;
      WriteRegister_o <= wreg_d;
      ALUResult_o     <= alu_d;
      ReadData_o      <= rdata_d;
      PCout           <= pc_d;
      AdEL            <= adel_d;
      AdES            <= ades_d;
      BadVAddr        <= badv_d;
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage placed directly downstream of the execute stage.
- Consumes the execute stage's ALU result (used as the address), store data, load type and control signals.
- Drives the data-side SRAM-like bus (req/addr_ok/data_ok), aligns and extends load data, and detects address-alignment exceptions.
- Registers results into the MEM/WB boundary and raises a stall to the hazard unit while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, address and data width
- REG_W, 7, destination-register index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid_i  in  1  execute-stage instruction valid
- flush  in  1  cancel instruction currently in this stage
- RegWrite_i  in  1  register-write enable from execute stage
- MemtoReg_i  in  1  writeback selects load data
- MemRead_i  in  1  load
- MemWrite_i  in  1  store
- MemReadType_i  in  3  [1:0] size (00 byte, 01 half, 10 word); [2]=1 zero-extend
- ALUResult_i  in  32  effective address / ALU value
- MemData_i  in  32  store data (forwarded B operand)
- WriteRegister_i  in  REG_W  destination register
- PCin  in  32  instruction PC
- exception_i  in  1  upstream exception already pending
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  00 byte, 01 half, 10 word
- data_addr  out  32  bus address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  raw read word
- stall  out  1  hold upstream stages
- valid_o  out  1  MEM/WB instruction valid
- RegWrite_o  out  1  registered RegWrite, gated by valid and exception
- MemtoReg_o  out  1  registered
- WriteRegister_o  out  REG_W  registered
- ALUResult_o  out  32  registered
- ReadData_o  out  32  aligned, extended load data
- PCout  out  32  registered PC
- AdEL  out  1  load address error
- AdES  out  1  store address error
- BadVAddr  out  32  faulting address

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all registered outputs 0, data_req=0, stall=0.
- An instruction is a memory op when valid_i & (MemRead_i|MemWrite_i) & !exception_i & !flush.
- Misaligned when size=01 and addr[0]=1, or size=10 and addr[1:0]!=0. Misaligned ops raise AdEL (load) or AdES (store), set BadVAddr=ALUResult_i, issue no bus request, and force RegWrite_o=0. All outputs are registered with 1-cycle latency.
- FSM states and transitions:
  - IDLE: on an aligned memory op, assert data_req combinationally in the same cycle. If data_addr_ok=1, go to WAIT; otherwise go to REQ.
  - REQ: hold data_req and all bus fields stable (latched copies). On data_addr_ok, go to WAIT.
  - WAIT: data_req=0. On data_data_ok, capture the result and go to IDLE.
- data_addr = address with low bits kept; data_size = MemReadType_i[1:0].
- Store lane replication: byte → {4{d[7:0]}}, half → {2{d[15:0]}}, word unchanged.
- Load extraction: select the byte at addr[1:0] or the half at addr[1]; sign- or zero-extend per MemReadType[2].
- stall = (IDLE & memory op & !(addr_ok & data_ok same cycle)) | REQ | (WAIT & !data_data_ok).
- The MEM/WB register updates only when stall=0. While stalled, valid_o=0 is presented (bubble).
- Non-memory instructions pass through in one cycle. ReadData_o is a don't-care (driven 0).
- flush while IDLE: the instruction becomes a bubble (valid_o=0).
- flush in REQ or WAIT: the bus handshake must complete (no cancel). The response is discarded, valid_o=0 and RegWrite_o=0, and stall is held until data_data_ok.
- Only one transaction is outstanding at a time. A data_data_ok arriving in IDLE is ignored.
- Reset mid-transaction returns to IDLE immediately. The bus side is reset by the same signal.

Test Plan:
- Aligned lw: ALUResult_i=0x80001004, addr_ok in cycle 0, data_ok in cycle 2, rdata=0xDEADBEEF → stall high for cycles 0–1; ReadData_o=0xDEADBEEF, RegWrite_o=1 after cycle 2.
- lb at addr ...03, rdata=0x80112233, type=000 → ReadData_o=0xFFFFFF80. Same access with lbu (type=100) → 0x00000080.
- sh of 0x1234ABCD at addr ...02 → data_wr=1, data_size=01, data_wdata=0xABCDABCD, RegWrite_o=0.
- lw at 0x80001002 → no data_req; AdEL=1, BadVAddr=0x80001002, RegWrite_o=0, no stall. sw at the same address → AdES=1.
- addr_ok withheld for 3 cycles → data_req held with stable addr and wdata; stall stays high throughout.
- flush asserted in WAIT → stall held until data_ok, then valid_o=0 and RegWrite_o=0. Next instruction proceeds normally.
